// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook-time countdown.
package microwave_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        COUNT = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True for a keypad code that is a legal BCD digit (0-9).
    function automatic logic bcd_is_digit(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts enabled cycles, pulses tick on the last one.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    input  logic zero,
    output logic tick
);

    localparam int PRE_W = $clog2(TICKS_PER_SEC);
    localparam logic [PRE_W-1:0] TERM = PRE_W'(TICKS_PER_SEC - 1);

    logic [PRE_W-1:0] cnt;

    // tick is only meaningful while enabled, so a held count never fires it.
    assign tick = en && (cnt == TERM);

    // Prescaler: sync zero wins, otherwise count enabled cycles and wrap at TERM.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt <= '0;
        end else if (zero) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == TERM) cnt <= '0;
            else             cnt <= cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/microwave_timer.sv
// Cook-time countdown: MM:SS entered as BCD digits, decremented once per
// second while the magnetron is on, timer_done raised at 00:00.
//
//   state | meaning
//   SETUP | keypad entry; mag_on starts counting (or finishes at 00:00)
//   COUNT | magnetron on, prescaler running, time decrementing
//   PAUSE | magnetron off mid-cook; prescaler and time held
//   DONE  | time reached 00:00, timer_done high
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             mag_on,
    input  logic [BCD_W-1:0] digit,
    input  logic             load_en,
    input  logic             clear_time,
    output logic             timer_done,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             time_zero
);

    state_t state, state_nxt;

    logic [BCD_W-1:0] mt_nxt, mo_nxt, st_nxt, so_nxt;
    logic [BCD_W-1:0] mt_dec, mo_dec, st_dec, so_dec;
    logic             dec_zero;
    logic             digit_ok;
    logic             tick;
    logic             pre_en;
    logic             pre_zero;

    assign digit_ok = bcd_is_digit(digit);
    assign pre_en   = mag_on && (state == COUNT);
    // Keep the prescaler at zero outside a cook so every COUNT entry starts fresh.
    assign pre_zero = clear_time || (state == SETUP) || (state == DONE);

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk  (clk),
        .clear(clear),
        .en   (pre_en),
        .zero (pre_zero),
        .tick (tick)
    );

    // State, time digits and timer_done register; timer_done follows the next state.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state      <= SETUP;
            min_tens   <= '0;
            min_ones   <= '0;
            sec_tens   <= '0;
            sec_ones   <= '0;
            timer_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            min_tens   <= mt_nxt;
            min_ones   <= mo_nxt;
            sec_tens   <= st_nxt;
            sec_ones   <= so_nxt;
            timer_done <= (state_nxt == DONE);
        end
    end

    // BCD decrement with borrow; saturates at 00:00.
    always_comb begin
        mt_dec = min_tens;
        mo_dec = min_ones;
        st_dec = sec_tens;
        so_dec = sec_ones;
        if (sec_ones != 4'd0) begin
            so_dec = sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
            st_dec = sec_tens - 4'd1;
            so_dec = 4'd9;
        end else if ((min_ones != 4'd0) || (min_tens != 4'd0)) begin
            st_dec = 4'd5;
            so_dec = 4'd9;
            if (min_ones != 4'd0) begin
                mo_dec = min_ones - 4'd1;
            end else begin
                mo_dec = 4'd9;
                mt_dec = min_tens - 4'd1;
            end
        end
        dec_zero = (mt_dec == 4'd0) && (mo_dec == 4'd0) &&
                   (st_dec == 4'd0) && (so_dec == 4'd0);
    end

    // Next state and next time: clear_time > tick/decrement > load_en.
    always_comb begin
        state_nxt = state;
        mt_nxt    = min_tens;
        mo_nxt    = min_ones;
        st_nxt    = sec_tens;
        so_nxt    = sec_ones;
        if (clear_time) begin
            state_nxt = SETUP;
            mt_nxt    = '0;
            mo_nxt    = '0;
            st_nxt    = '0;
            so_nxt    = '0;
        end else begin
            case (state)
                SETUP: begin
                    // A load takes the cycle; mag_on is looked at again next cycle.
                    if (load_en && digit_ok) begin
                        mt_nxt = min_ones;
                        mo_nxt = sec_tens;
                        st_nxt = sec_ones;
                        so_nxt = digit;
                    end else if (mag_on) begin
                        state_nxt = time_zero ? DONE : COUNT;
                    end
                end
                COUNT: begin
                    if (tick) begin
                        mt_nxt = mt_dec;
                        mo_nxt = mo_dec;
                        st_nxt = st_dec;
                        so_nxt = so_dec;
                        if (dec_zero) state_nxt = DONE;
                    end else if (!mag_on) begin
                        state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (mag_on) state_nxt = COUNT;
                end
                DONE: begin
                    // Time is already 00:00, so the new digit lands in sec_ones alone.
                    if (load_en && digit_ok) begin
                        state_nxt = SETUP;
                        mt_nxt    = '0;
                        mo_nxt    = '0;
                        st_nxt    = '0;
                        so_nxt    = digit;
                    end
                end
                default: state_nxt = SETUP;
            endcase
        end
    end

    // Display-side status: all four digits at zero.
    always_comb begin
        time_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd0);
    end

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer with a 4-cycle second.
module tb_microwave_timer;

    localparam int TPS = 4;

    logic       clk;
    logic       clear;
    logic       mag_on;
    logic [3:0] digit;
    logic       load_en;
    logic       clear_time;
    logic       timer_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       time_zero;

    microwave_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk       (clk),
        .clear     (clear),
        .mag_on    (mag_on),
        .digit     (digit),
        .load_en   (load_en),
        .clear_time(clear_time),
        .timer_done(timer_done),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .time_zero (time_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tm;
        logic        done;
    } exp_t;

    typedef struct {
        logic        ct;
        logic        le;
        logic [3:0]  dg;
        logic        mo;
        logic [15:0] tm;
        logic        done;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Pop the oldest expectation and compare it with the DUT right now.
    task automatic check_now(input string tag);
        exp_t        e;
        logic [15:0] act;
        logic        ez;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e   = sb.pop_front();
        act = {min_tens, min_ones, sec_tens, sec_ones};
        ez  = (e.tm == 16'h0000);
        n_cmp++;
        if (act !== e.tm || timer_done !== e.done || time_zero !== ez) begin
            n_bad++;
            $display("FAIL %s: got time=%h done=%b zero=%b, want time=%h done=%b zero=%b",
                     tag, act, timer_done, time_zero, e.tm, e.done, ez);
        end
    endtask

    // Drive one cycle of inputs, push its expectation, sample #1 after the edge.
    task automatic apply(input logic ct, input logic le, input logic [3:0] dg,
                         input logic mo, input logic [15:0] tm, input logic done,
                         input string tag);
        exp_t e;
        clear_time = ct;
        load_en    = le;
        digit      = dg;
        mag_on     = mo;
        e.tm       = tm;
        e.done     = done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    vec_t setup_vec[8];
    vec_t bad_vec[3];

    initial begin
        exp_t        e;
        logic [15:0] tm;

        setup_vec[0] = '{1'b0, 1'b1, 4'd1, 1'b0, 16'h0001, 1'b0};
        setup_vec[1] = '{1'b0, 1'b1, 4'd0, 1'b0, 16'h0010, 1'b0};
        setup_vec[2] = '{1'b0, 1'b0, 4'd7, 1'b0, 16'h0010, 1'b0};
        setup_vec[3] = '{1'b0, 1'b1, 4'd2, 1'b0, 16'h0102, 1'b0};
        setup_vec[4] = '{1'b0, 1'b1, 4'd3, 1'b0, 16'h1023, 1'b0};
        setup_vec[5] = '{1'b0, 1'b1, 4'd4, 1'b0, 16'h0234, 1'b0};
        setup_vec[6] = '{1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0};
        setup_vec[7] = '{1'b0, 1'b1, 4'd5, 1'b0, 16'h0005, 1'b0};

        bad_vec[0] = '{1'b0, 1'b1, 4'd12, 1'b0, 16'h0000, 1'b0};
        bad_vec[1] = '{1'b0, 1'b1, 4'd15, 1'b0, 16'h0000, 1'b0};
        bad_vec[2] = '{1'b0, 1'b1, 4'd9,  1'b0, 16'h0009, 1'b0};

        // Reset with undriven inputs.
        clear      = 1'b1;
        mag_on     = 1'bx;
        digit      = 4'bx;
        load_en    = 1'bx;
        clear_time = 1'bx;
        repeat (2) @(posedge clk);
        #1;
        e.tm = 16'h0000; e.done = 1'b0; sb.push_back(e);
        check_now("reset");
        mag_on = 1'b0; digit = 4'd0; load_en = 1'b0; clear_time = 1'b0;
        clear  = 1'b0;

        // Keypad entry, shifting, clear_time, then "5".
        foreach (setup_vec[i])
            apply(setup_vec[i].ct, setup_vec[i].le, setup_vec[i].dg, setup_vec[i].mo,
                  setup_vec[i].tm, setup_vec[i].done, "setup_vec");

        // Countdown 00:05: one edge to enter COUNT, then a decrement every TPS edges.
        for (int k = 1; k <= 5 * TPS + 1; k++) begin
            tm = 16'(5 - (k - 1) / TPS);
            apply(1'b0, 1'b0, 4'd0, 1'b1, tm, (k == 5 * TPS + 1), "countdown");
        end
        for (int k = 0; k < 3; k++)
            apply(1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b1, "done_hold");
        apply(1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, "clear_time_done");

        // Minute borrow: 01:00 -> 00:59.
        apply(1'b0, 1'b1, 4'd1, 1'b0, 16'h0001, 1'b0, "load_100");
        apply(1'b0, 1'b1, 4'd0, 1'b0, 16'h0010, 1'b0, "load_100");
        apply(1'b0, 1'b1, 4'd0, 1'b0, 16'h0100, 1'b0, "load_100");
        for (int k = 1; k <= TPS; k++)
            apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0100, 1'b0, "borrow_wait");
        apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0059, 1'b0, "borrow_min");
        apply(1'b0, 1'b0, 4'd0, 1'b0, 16'h0059, 1'b0, "borrow_pause");
        apply(1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, "clear_time_pause");

        // "90" counts as 90 seconds: 00:90 -> 00:89 -> 00:88.
        apply(1'b0, 1'b1, 4'd9, 1'b0, 16'h0009, 1'b0, "load_90");
        apply(1'b0, 1'b1, 4'd0, 1'b0, 16'h0090, 1'b0, "load_90");
        for (int k = 1; k <= 2 * TPS + 1; k++) begin
            tm = (k <= TPS) ? 16'h0090 : (k <= 2 * TPS) ? 16'h0089 : 16'h0088;
            apply(1'b0, 1'b0, 4'd0, 1'b1, tm, 1'b0, "count_90");
        end
        apply(1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, "clear_time_count");

        // Pause with prescaler at 2: time holds, resumes from the held count.
        apply(1'b0, 1'b1, 4'd3, 1'b0, 16'h0003, 1'b0, "load_3");
        for (int k = 0; k < 3; k++)
            apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0003, 1'b0, "pre_pause");
        for (int k = 0; k < 10; k++)
            apply(1'b0, (k == 4), 4'd8, 1'b0, 16'h0003, 1'b0, "paused");
        apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0003, 1'b0, "resume_enter");
        apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0003, 1'b0, "resume_cnt3");
        apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0002, 1'b0, "resume_tick");
        apply(1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, "clear_time_resume");

        // Zero start goes straight to DONE; load from DONE; clear_time beats load_en.
        apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 1'b1, "zero_start");
        apply(1'b0, 1'b1, 4'd7, 1'b0, 16'h0007, 1'b0, "done_load");
        apply(1'b1, 1'b1, 4'd3, 1'b0, 16'h0000, 1'b0, "clear_vs_load");

        // Load and mag_on together: load wins, then COUNT next cycle.
        apply(1'b0, 1'b1, 4'd2, 1'b1, 16'h0002, 1'b0, "load_with_mag");
        apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0002, 1'b0, "enter_count");
        apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0002, 1'b0, "counting");
        apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0002, 1'b0, "counting");

        // Async clear between edges.
        mag_on = 1'b0;
        clear  = 1'b1;
        #2;
        e.tm = 16'h0000; e.done = 1'b0; sb.push_back(e);
        check_now("async_clear");
        #1;
        clear = 1'b0;
        @(posedge clk);
        #1;
        e.tm = 16'h0000; e.done = 1'b0; sb.push_back(e);
        check_now("after_clear");

        // Non-BCD keypad codes are ignored.
        foreach (bad_vec[i])
            apply(bad_vec[i].ct, bad_vec[i].le, bad_vec[i].dg, bad_vec[i].mo,
                  bad_vec[i].tm, bad_vec[i].done, "bad_digit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
Cook-time countdown that produces the timer_done input consumed by the magnetron on/off controller, and consumes that controller's mag_on output. The operator keys in an MM:SS time as BCD digits, which shift in from the right. The time counts down one second per prescaled tick while mag_on is high and pauses while mag_on is low. It asserts timer_done at 00:00 so the controller drops mag_on.

Parameters:
TICKS_PER_SEC, 1000, clk cycles per one-second decrement (1 ms clock); legal range ≥2.
PRE_W, $clog2(TICKS_PER_SEC), prescaler width (derived, not overridden).

Ports:
clk  input  1  system clock, rising-edge.
clear  input  1  async active-high reset.
mag_on  input  1  magnetron enable from the controller; time counts only while high.
digit  input  4  BCD keypad digit.
load_en  input  1  one-cycle strobe to shift digit in.
clear_time  input  1  sync strobe: zero the time, return to SETUP.
timer_done  output  1  high while in DONE.
min_tens, min_ones, sec_tens, sec_ones  output  4 each  current time in BCD.
time_zero  output  1  combinational: all four digits are 0.

Behaviour:
- One clock; reset is asynchronous and active-high (clk, clear). All regs are async-cleared by clear: state=SETUP, all digits 0, prescaler 0, timer_done 0. clear asserted mid-count aborts immediately.
- States: SETUP, COUNT, PAUSE, DONE.
- SETUP:
  - load_en with digit≤9: {min_tens,min_ones,sec_tens,sec_ones} ← {min_ones,sec_tens,sec_ones,digit}.
  - digit>9: strobe ignored.
  - Any digit 0-9 is accepted in any position, so sec_tens may be 6-9 (e.g. "90" = 90 s).
  - mag_on=1 and time≠0 → COUNT, prescaler←0.
  - mag_on=1 and time=0 → DONE next edge.
  - load_en and mag_on in the same cycle: the load is applied; the transition is evaluated on the next cycle.
- COUNT:
  - Each cycle with mag_on=1, prescaler increments.
  - At prescaler=TICKS_PER_SEC-1: prescaler←0 and time decrements once. First decrement occurs TICKS_PER_SEC cycles after entering COUNT.
  - mag_on=0 → PAUSE; prescaler and time hold. No decrement in any cycle where mag_on=0.
- Decrement rules (BCD, per digit, with borrow):
  - sec_ones>0: sec_ones-1.
  - Else sec_tens>0: sec_tens-1, sec_ones=9.
  - Else minutes>0: sec=59, minutes decremented in BCD (ones 0 → 9 with borrow from tens).
  - Never decrements below 00:00.
- At the edge where the result becomes 00:00: state←DONE and timer_done←1 on the same edge.
- PAUSE:
  - mag_on=1 → COUNT, prescaler resumes from its held value.
  - load_en is ignored.
- DONE:
  - timer_done=1 and time=0.
  - load_en (valid digit) → SETUP, timer_done←0, digit shifted into the zero time on the same edge.
- clear_time: in any state → SETUP, digits 0, prescaler 0, timer_done 0. It has priority over load_en and tick in the same cycle.
- Priority per cycle: clear (async) > clear_time > tick/decrement > load_en.
- No combinational path from inputs to timer_done.

Decomposition:
- Package microwave_pkg: state encoding constants (SETUP=2'd0, COUNT=2'd1, PAUSE=2'd2, DONE=2'd3) and BCD_W=4.
- Sub-module sec_tick_gen: prescaler with enable (mag_on & state==COUNT), sync zero, and a one-cycle tick output; parameterised by TICKS_PER_SEC.
- BCD decrement and shift logic stay in microwave_timer.

Test Plan (TICKS_PER_SEC=4):
- Reset: clear=1 with inputs X → all digits 0, timer_done=0, time_zero=1. Release clear; load 1,0 → display 00:10.
- Countdown with entry "5": mag_on=1 → 00:04 after 4 cycles, 00:00 after 20 cycles with timer_done=1 on that same edge. Drop mag_on → timer_done stays 1.
- Borrow across minute: load "100" (01:00), count one tick → 00:59. Load "90" → ticks give 00:89, 00:88.
- Pause: 00:03 counting, mag_on low for 10 cycles after 2 prescaler counts → time holds at 00:03. mag_on high → 00:02 exactly 2 cycles later.
- Zero start and clear_time: mag_on=1 with 00:00 → timer_done=1 next edge. In DONE, load_en digit=7 → timer_done=0, 00:07. clear_time with load_en the same cycle → 00:00, SETUP.
- Async reset mid-COUNT at 00:02: clear pulse between edges → immediately 00:00, timer_done=0. Digit>9 load → ignored.
